// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential fetch requests under a credit
// limit, buffers in-order responses with their PC, and flushes on redirect.
module fetch_queue #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_imem_req_addr,
    input  logic                  i_imem_resp_valid,
    input  logic [31:0]           i_imem_resp_data,
    input  logic                  i_imem_resp_fault,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_instr_valid,
    output logic [31:0]           o_instr,
    output logic [ADDR_WIDTH-1:0] o_instr_pc,
    output logic                  o_instr_fault,
    input  logic                  i_decode_ready
);
    localparam int          PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Handshake rule on both channels: a transfer happens on a rising edge
    // where valid && ready; while valid && !ready the producer holds its payload.

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [31:0]           fifo_instr [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc    [QUEUE_DEPTH];
    logic                  fifo_fault [QUEUE_DEPTH];
    logic [CNT_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      discard;
    logic [CNT_W:0]        credit_used;
    logic [PTR_W-1:0]      rd_idx;
    logic [PTR_W-1:0]      wr_idx;
    logic                  fifo_empty;
    logic                  req_fire;
    logic                  push;
    logic                  pop;

    assign redirect_target = i_redirect_pc & ~ADDR_WIDTH'(3);
    assign occupancy       = wr_ptr - rd_ptr;
    assign credit_used     = {1'b0, occupancy} + {1'b0, outstanding};
    assign fifo_empty      = (occupancy == '0);
    assign rd_idx          = rd_ptr[PTR_W-1:0];
    assign wr_idx          = wr_ptr[PTR_W-1:0];

    // Buffered entries plus in-flight requests never exceed the FIFO depth,
    // so every response that comes back always has a slot.
    assign o_imem_req_valid = !i_rst && !i_redirect_valid
                              && (credit_used < (CNT_W+1)'(QUEUE_DEPTH));
    assign o_imem_req_addr  = fetch_pc;
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

    assign push = i_imem_resp_valid && !i_redirect_valid && (discard == '0);

    assign o_instr_valid = !i_rst && !fifo_empty;
    assign o_instr       = o_instr_valid ? fifo_instr[rd_idx] : '0;
    assign o_instr_pc    = o_instr_valid ? fifo_pc[rd_idx]    : '0;
    assign o_instr_fault = o_instr_valid ? fifo_fault[rd_idx] : 1'b0;
    assign pop           = o_instr_valid && i_decode_ready && !i_redirect_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(i_imem_resp_valid);
            if (i_redirect_valid) begin
                // Everything still in flight (less this cycle's response) is stale.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                discard  <= outstanding - CNT_W'(i_imem_resp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                end
                if (i_imem_resp_valid && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + CNT_W'(1);
                    resp_pc <= resp_pc + ADDR_WIDTH'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_instr[wr_idx] <= i_imem_resp_fault ? NOP_INSTR : i_imem_resp_data;
            fifo_pc[wr_idx]    <= resp_pc;
            fifo_fault[wr_idx] <= i_imem_resp_fault;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: an in-order 1-cycle memory responder plus a
// linear sequence of decode/redirect/reset steps with hand-computed PCs.
module tb_fetch_queue;
    logic        i_clk;
    logic        i_rst;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [63:0] o_imem_req_addr;
    logic        i_imem_resp_valid;
    logic [31:0] i_imem_resp_data;
    logic        i_imem_resp_fault;
    logic        i_redirect_valid;
    logic [63:0] i_redirect_pc;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [63:0] o_instr_pc;
    logic        o_instr_fault;
    logic        i_decode_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // Memory responder controls: random ready, and response budget (-1 = unlimited).
    bit          rand_ready  = 0;
    int          resp_budget = -1;
    logic [63:0] inflight_q[$];
    localparam logic [63:0] FAULT_ADDR = 64'h8;

    fetch_queue #(
        .ADDR_WIDTH (64),
        .QUEUE_DEPTH(4),
        .RESET_PC   (64'h0)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_resp_valid(i_imem_resp_valid),
        .i_imem_resp_data (i_imem_resp_data),
        .i_imem_resp_fault(i_imem_resp_fault),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_instr_valid    (o_instr_valid),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .o_instr_fault    (o_instr_fault),
        .i_decode_ready   (i_decode_ready)
    );

    // Clock and reset defaults
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: accepts on valid&&ready, answers in order one cycle later.
    initial begin
        logic        rst_s;
        logic        acc_s;
        logic [63:0] addr_s;
        logic        prev_stall;
        logic [63:0] prev_addr;
        logic [63:0] head;
        prev_stall        = 1'b0;
        prev_addr         = '0;
        i_imem_req_ready  = 1'b1;
        i_imem_resp_valid = 1'b0;
        i_imem_resp_data  = '0;
        i_imem_resp_fault = 1'b0;
        forever begin
            @(negedge i_clk);
            rst_s  = i_rst;
            acc_s  = o_imem_req_valid && i_imem_req_ready;
            addr_s = o_imem_req_addr;
            if (prev_stall && o_imem_req_valid && !i_rst)
                check("req_addr_stable", o_imem_req_addr, prev_addr);
            prev_stall = o_imem_req_valid && !i_imem_req_ready && !i_redirect_valid;
            prev_addr  = o_imem_req_addr;
            @(posedge i_clk);
            #2;
            if (rst_s) begin
                inflight_q.delete();
            end else begin
                if (i_imem_resp_valid) void'(inflight_q.pop_front());
                if (acc_s) inflight_q.push_back(addr_s);
            end
            i_imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rst_s && (inflight_q.size() > 0) && (resp_budget != 0)) begin
                head              = inflight_q[0];
                i_imem_resp_valid = 1'b1;
                i_imem_resp_data  = ~head[31:0];
                i_imem_resp_fault = (head == FAULT_ADDR);
                if (resp_budget > 0) resp_budget--;
            end else begin
                i_imem_resp_valid = 1'b0;
                i_imem_resp_data  = '0;
                i_imem_resp_fault = 1'b0;
            end
        end
    end

    // Waits (bounded) for a head entry, checks it, pops it at the next edge.
    task automatic take(input logic [63:0] pc, input logic flt, input int exp_wait);
        int          w;
        bit          got;
        logic [31:0] exp_instr;
        w   = 0;
        got = 0;
        exp_instr = flt ? 32'h0000_0013 : ~pc[31:0];
        i_decode_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge i_clk);
            if (o_instr_valid) begin
                got = 1;
                break;
            end
            w++;
        end
        check("instr_valid_timeout", 64'(got), 64'(1));
        if (got) begin
            check("instr_pc", o_instr_pc, pc);
            check("instr_word", 64'(o_instr), 64'(exp_instr));
            check("instr_fault", 64'(o_instr_fault), 64'(flt));
            if (exp_wait >= 0) check("instr_wait_cycles", 64'(w), 64'(exp_wait));
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", 64'(o_imem_req_valid), 64'(0));
        check("rst_instr_valid", 64'(o_instr_valid), 64'(0));
        check("rst_instr", 64'(o_instr), 64'(0));
        check("rst_instr_pc", o_instr_pc, 64'(0));
        check("rst_instr_fault", 64'(o_instr_fault), 64'(0));
    endtask

    initial begin
        i_rst            = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_decode_ready   = 1'b0;

        // Reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Free-running fetch, 2-cycle fill, fault at 0x8
        take(64'h0, 1'b0, 2);
        take(64'h4, 1'b0, 0);
        take(64'h8, 1'b1, 0);
        for (int i = 3; i < 8; i++) take(64'(4 * i), 1'b0, 0);

        // Decode stall: four entries buffered, requests stop, head held
        i_decode_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        check("stall_head_pc_early", o_instr_pc, 64'h20);
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        check("stall_instr_valid", 64'(o_instr_valid), 64'(1));
        check("stall_head_pc", o_instr_pc, 64'h20);
        check("stall_req_valid", 64'(o_imem_req_valid), 64'(0));
        check("stall_occupancy", 64'(dut.occupancy), 64'(4));
        @(posedge i_clk);
        #1;
        for (int i = 8; i < 13; i++) take(64'(4 * i), 1'b0, 0);

        // Random request back-pressure
        rand_ready = 1;
        for (int i = 13; i < 25; i++) take(64'(4 * i), 1'b0, -1);
        rand_ready  = 0;

        // Hold responses: drain FIFO, four requests pile up in flight
        resp_budget = 0;
        repeat (12) @(posedge i_clk);
        @(negedge i_clk);
        check("hold_instr_valid", 64'(o_instr_valid), 64'(0));
        check("hold_req_valid", 64'(o_imem_req_valid), 64'(0));
        @(posedge i_clk);
        #1;
        i_decode_ready = 1'b0;
        resp_budget    = 1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("pre_redir_instr_valid", 64'(o_instr_valid), 64'(1));
        check("pre_redir_req_valid", 64'(o_imem_req_valid), 64'(0));
        check("pre_redir_outstanding", 64'(dut.outstanding), 64'(3));

        // Redirect to 0x1002: flush 1 buffered, drop 3 stale responses
        @(posedge i_clk);
        #1;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 64'h1002;
        @(negedge i_clk);
        check("redir_req_valid", 64'(o_imem_req_valid), 64'(0));
        @(posedge i_clk);
        #1;
        i_redirect_valid = 1'b0;
        resp_budget      = -1;
        @(negedge i_clk);
        check("redir_flushed", 64'(o_instr_valid), 64'(0));
        check("redir_fetch_addr", o_imem_req_addr, 64'h1000);
        take(64'h1000, 1'b0, -1);
        take(64'h1004, 1'b0, 0);
        take(64'h1008, 1'b0, 0);
        take(64'h100C, 1'b0, 0);
        take(64'h1010, 1'b0, 0);

        // Redirect with response and pop in flight, then override to 0x200
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 64'h3000;
        @(negedge i_clk);
        check("redir1_head_valid", 64'(o_instr_valid), 64'(1));
        @(posedge i_clk);
        #1;
        i_redirect_pc = 64'h200;
        @(negedge i_clk);
        check("redir2_req_valid", 64'(o_imem_req_valid), 64'(0));
        check("redir2_flushed", 64'(o_instr_valid), 64'(0));
        @(posedge i_clk);
        #1;
        i_redirect_valid = 1'b0;
        take(64'h200, 1'b0, -1);
        take(64'h204, 1'b0, 0);
        take(64'h208, 1'b0, 0);

        // Idle with decode stalled: counters settle, FIFO full from 0x20C
        i_decode_ready = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        check("idle_head_pc", o_instr_pc, 64'h20C);
        check("idle_req_valid", 64'(o_imem_req_valid), 64'(0));
        check("idle_outstanding", 64'(dut.outstanding), 64'(0));
        check("idle_discard", 64'(dut.discard), 64'(0));
        @(posedge i_clk);
        #1;
        for (int i = 0; i < 4; i++) take(64'(64'h20C + 4 * i), 1'b0, 0);

        // Reset mid-operation, then restart from RESET_PC
        i_rst = 1'b1;
        @(negedge i_clk);
        check_reset_outputs();
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        take(64'h0, 1'b0, 2);
        take(64'h4, 1'b0, 0);
        take(64'h8, 1'b1, 0);
        take(64'hC, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
